// File: rtl/pico_receiver.sv
// pico_receiver: PICO serial command receiver feeding a POCI register block.
// Deserialises an LSB-first command byte (bit 7 = write, bits 6:0 = address)
// and, for writes, a data byte. It sequences POCI's control/write-data inputs
// so write_data settles one cycle before a writable address is presented.
// Ports:
//   sclk           serial clock, all state updates on rising edge
//   rstn           asynchronous active-low reset
//   cs             frame enable, active-high; low returns to IDLE
//   serial_in      PICO data, LSB first
//   control_signal address to POCI, 0 when no command is active
//   write_data     last accepted write byte, held until the next write
//   write_pulse    one-cycle strobe when a write address is presented
//   frame_err      one-cycle strobe on an invalid command
module pico_receiver #(
  parameter int unsigned MAX_ADDR = 59,
  parameter int unsigned NUM_WR   = 3
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       cs,
  input  logic       serial_in,
  output logic [7:0] control_signal,
  output logic [7:0] write_data,
  output logic       write_pulse,
  output logic       frame_err
);

  localparam logic [6:0] MaxA = 7'(MAX_ADDR);
  localparam logic [6:0] NumW = 7'(NUM_WR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] wdata_q, wdata_d;
  logic       pulse_q, pulse_d;
  logic       err_q, err_d;

  // Shift registers with the current serial bit already merged in, so the
  // completing edge can decode the full byte.
  logic [7:0] a_full;
  logic [7:0] d_full;
  logic       rd_ok;
  logic       wr_ok;
  logic       last_bit;

  always_comb begin
    a_full            = addr_q;
    a_full[bit_cnt_q] = serial_in;
    d_full            = data_q;
    d_full[bit_cnt_q] = serial_in;
  end

  assign rd_ok    = (a_full[6:0] <= MaxA);
  assign wr_ok    = (addr_q[6:0] != 7'd0) && (addr_q[6:0] <= NumW);
  assign last_bit = (bit_cnt_q == 3'd7);

  // State register
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!cs) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ADDR;
        ADDR: if (last_bit) state_d = a_full[7] ? DATA : HOLD;
        DATA: if (last_bit) state_d = HOLD;
        HOLD: if (last_bit) state_d = ADDR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    wdata_d   = wdata_q;
    pulse_d   = 1'b0;
    err_d     = 1'b0;
    if (!cs) begin
      // Abort: drop the partial frame, keep write_data.
      bit_cnt_d = 3'd0;
      ctrl_d    = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_d    = {7'd0, serial_in};
          bit_cnt_d = 3'd1;
          ctrl_d    = 8'd0;
        end
        ADDR: begin
          addr_d    = a_full;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit && !a_full[7]) begin
            if (rd_ok) ctrl_d = {1'b0, a_full[6:0]};
            else       err_d  = 1'b1;
          end
        end
        DATA: begin
          data_d    = d_full;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (last_bit) begin
            if (wr_ok) wdata_d = d_full;
            else       err_d   = 1'b1;
          end
        end
        HOLD: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          // Address follows write_data by one cycle for latch safety.
          if ((bit_cnt_q == 3'd0) && addr_q[7] && wr_ok) begin
            ctrl_d  = {1'b0, addr_q[6:0]};
            pulse_d = 1'b1;
          end
          if (last_bit) ctrl_d = 8'd0;
        end
        default: begin
          bit_cnt_d = 3'd0;
          ctrl_d    = 8'd0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_q <= 3'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      ctrl_q    <= 8'd0;
      wdata_q   <= 8'd0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      wdata_q   <= wdata_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  assign control_signal = ctrl_q;
  assign write_data     = wdata_q;
  assign write_pulse    = pulse_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_pico_receiver.sv
// Directed bench for pico_receiver: per-edge expectations derived from the
// frame timing are queued before each frame and checked after every edge.
module tb_pico_receiver;

  localparam int unsigned MAX_A = 59;
  localparam int unsigned NUM_W = 3;

  logic       sclk = 1'b0;
  logic       rstn = 1'b0;
  logic       cs = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] control_signal;
  logic [7:0] write_data;
  logic       write_pulse;
  logic       frame_err;

  pico_receiver #(.MAX_ADDR(MAX_A), .NUM_WR(NUM_W)) dut (
    .sclk           (sclk),
    .rstn           (rstn),
    .cs             (cs),
    .serial_in      (serial_in),
    .control_signal (control_signal),
    .write_data     (write_data),
    .write_pulse    (write_pulse),
    .frame_err      (frame_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] wd;
    logic       pulse;
    logic       err;
    int         edge_no;
  } exp_t;

  exp_t       exp_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  string      tag = "reset";
  logic [7:0] exp_wd = 8'h00;

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s %s observed=%h expected=%h", tag, name, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] c, input logic [7:0] w,
                          input logic p, input logic e, input int n);
    exp_t x;
    x.ctrl = c; x.wd = w; x.pulse = p; x.err = e; x.edge_no = n;
    exp_q.push_back(x);
  endtask

  // Drive one bit away from the edge, clock it, then check the next expectation.
  task automatic tick(input logic c, input logic b);
    exp_t x;
    @(negedge sclk);
    cs = c;
    serial_in = b;
    @(posedge sclk);
    #1;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h expected=nonempty", tag, control_signal);
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      chk($sformatf("ctrl@e%0d", x.edge_no), control_signal, x.ctrl);
      chk($sformatf("wdata@e%0d", x.edge_no), write_data, x.wd);
      chk($sformatf("pulse@e%0d", x.edge_no), {7'd0, write_pulse}, {7'd0, x.pulse});
      chk($sformatf("err@e%0d", x.edge_no), {7'd0, frame_err}, {7'd0, x.err});
    end
  endtask

  task automatic do_read(input logic [7:0] a);
    logic       ok;
    logic [7:0] c;
    ok = ({25'd0, a[6:0]} <= MAX_A);
    for (int e = 1; e <= 16; e++) begin
      c = (ok && e >= 8 && e <= 15) ? {1'b0, a[6:0]} : 8'h00;
      push_exp(c, exp_wd, 1'b0, (!ok && e == 8), e);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, a[i]);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    logic       ok;
    logic [7:0] c;
    logic [7:0] w;
    ok = (a[6:0] != 7'd0) && ({25'd0, a[6:0]} <= NUM_W);
    for (int e = 1; e <= 24; e++) begin
      c = (ok && e >= 17 && e <= 23) ? {1'b0, a[6:0]} : 8'h00;
      w = (ok && e >= 16) ? d : exp_wd;
      push_exp(c, w, (ok && e == 17), (!ok && e == 16), e);
    end
    if (ok) exp_wd = d;
    for (int i = 0; i < 8; i++) tick(1'b1, a[i]);
    for (int i = 0; i < 8; i++) tick(1'b1, d[i]);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
  endtask

  task automatic go_idle();
    push_exp(8'h00, exp_wd, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;

    // Reset values
    #2;
    chk("rst_ctrl", control_signal, 8'h00);
    chk("rst_wdata", write_data, 8'h00);
    chk("rst_pulse", {7'd0, write_pulse}, 8'h00);
    chk("rst_err", {7'd0, frame_err}, 8'h00);
    #20;
    rstn = 1'b1;
    go_idle();

    tag = "read5";      do_read(8'h05);
    tag = "write2_A5";  do_write(8'h82, 8'hA5);
    tag = "readback2";  do_read(8'h02);
    tag = "write_ro10"; do_write(8'h8A, 8'hFF);
    tag = "read_oor60"; do_read(8'h3C);
    tag = "read5_next"; do_read(8'h05);
    tag = "read0";      do_read(8'h00);
    tag = "write_adr0"; do_write(8'h80, 8'h11);
    tag = "write3_5A";  do_write(8'h83, 8'h5A);
    tag = "read59";     do_read(8'h3B);
    tag = "idle";       go_idle();

    // cs dropped after edge 12 of a write to address 1
    tag = "cs_drop";
    a = 8'h81;
    d = 8'hC3;
    for (int e = 1; e <= 12; e++) push_exp(8'h00, exp_wd, 1'b0, 1'b0, e);
    for (int i = 0; i < 8; i++) tick(1'b1, a[i]);
    for (int i = 0; i < 4; i++) tick(1'b1, d[i]);
    go_idle();
    go_idle();
    tag = "after_drop"; do_write(8'h81, 8'h3C);
    tag = "idle2";      go_idle();

    // Asynchronous reset during HOLD of a read of address 7
    tag = "rst_hold";
    a = 8'h07;
    for (int e = 1; e <= 12; e++) push_exp((e >= 8) ? 8'h07 : 8'h00, exp_wd, 1'b0, 1'b0, e);
    for (int i = 0; i < 8; i++) tick(1'b1, a[i]);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_ctrl", control_signal, 8'h00);
    chk("async_wdata", write_data, 8'h00);
    chk("async_pulse", {7'd0, write_pulse}, 8'h00);
    chk("async_err", {7'd0, frame_err}, 8'h00);
    exp_wd = 8'h00;
    go_idle();
    go_idle();
    #2;
    rstn = 1'b1;
    tag = "read7_post"; do_read(8'h07);
    tag = "write1_post"; do_write(8'h81, 8'h96);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
